// File: rtl/act_sparse_encoder.sv
// Purpose: turns dense activation rows into a flag word plus nonzero bytes (ascending element order), framed ROWS rows deep.
// Latency: flag write 1 cycle after row acceptance, data writes follow back to back, next row accepted 2+popcount cycles later.
// Backpressure: wr_ready low freezes state and all write outputs; in_ready is only high while waiting for a row.
module act_sparse_encoder #(
  parameter int DATA_WIDTH      = 8,
  parameter int IF_WIDTH        = 16,
  parameter int ROWS            = 16,
  parameter int ACT_INDEX_WIDTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [IF_WIDTH*DATA_WIDTH-1:0] in_data,
  input  logic                           wr_ready,
  output logic                           wr_req_act_flag,
  output logic [IF_WIDTH-1:0]            wr_data_act_flag,
  output logic                           wr_req_act,
  output logic [DATA_WIDTH-1:0]          wr_data_act,
  output logic [ACT_INDEX_WIDTH-1:0]     act_index,
  output logic [ACT_INDEX_WIDTH-1:0]     row_index,
  output logic [ACT_INDEX_WIDTH:0]       row_val_num,
  output logic                           busy,
  output logic                           frame_done
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FLAG, S_DATA, S_DONE} state_t;

  state_t                           state_q, state_d;
  logic [IF_WIDTH*DATA_WIDTH-1:0]   row_q, row_d;
  logic [IF_WIDTH-1:0]              flag_q, flag_d;
  logic [IF_WIDTH-1:0]              pend_q, pend_d;
  logic [ACT_INDEX_WIDTH-1:0]       row_index_q, row_index_d;
  logic [ACT_INDEX_WIDTH:0]         row_val_num_q, row_val_num_d;

  logic [IF_WIDTH-1:0]              in_mask;
  logic [ACT_INDEX_WIDTH:0]         in_pop;
  logic [ACT_INDEX_WIDTH-1:0]       pick_idx;
  logic [IF_WIDTH-1:0]              pick_mask;
  logic [DATA_WIDTH-1:0]            pick_byte;
  logic [IF_WIDTH-1:0]              pend_left;
  logic                             last_row;
  state_t                           row_end_state;

  // Nonzero mask and popcount of the incoming row; flag bit j tracks the byte in slice j.
  always_comb begin
    in_mask = '0;
    in_pop  = '0;
    for (int j = 0; j < IF_WIDTH; j++) begin
      in_mask[j] = |in_data[j*DATA_WIDTH +: DATA_WIDTH];
      in_pop     = in_pop + {{ACT_INDEX_WIDTH{1'b0}}, in_mask[j]};
    end
  end

  // Lowest-numbered pending element (element 0 lives in the flag MSB); scanning downward lets the lowest win.
  always_comb begin
    pick_idx  = '0;
    pick_mask = '0;
    pick_byte = '0;
    for (int i = IF_WIDTH-1; i >= 0; i--) begin
      if (pend_q[IF_WIDTH-1-i]) begin
        pick_idx                = ACT_INDEX_WIDTH'(i);
        pick_mask               = '0;
        pick_mask[IF_WIDTH-1-i] = 1'b1;
        pick_byte               = row_q[(IF_WIDTH-1-i)*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign pend_left     = pend_q & ~pick_mask;
  assign last_row      = (row_index_q == ACT_INDEX_WIDTH'(ROWS-1));
  assign row_end_state = last_row ? S_DONE : S_LOAD;

  // State and datapath registers; reset also discards the buffered row.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      row_q         <= '0;
      flag_q        <= '0;
      pend_q        <= '0;
      row_index_q   <= '0;
      row_val_num_q <= '0;
    end else begin
      state_q       <= state_d;
      row_q         <= row_d;
      flag_q        <= flag_d;
      pend_q        <= pend_d;
      row_index_q   <= row_index_d;
      row_val_num_q <= row_val_num_d;
    end
  end

  // Next-state logic: a write only advances the FSM on the cycle wr_ready accepts it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start)    state_d = S_LOAD;
      S_LOAD: if (in_valid) state_d = S_FLAG;
      S_FLAG: if (wr_ready) state_d = (flag_q == '0) ? row_end_state : S_DATA;
      S_DATA: if (wr_ready && (pend_left == '0)) state_d = row_end_state;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath updates: capture row on accept, retire one pending element per accepted data write.
  always_comb begin
    row_d         = row_q;
    flag_d        = flag_q;
    pend_d        = pend_q;
    row_index_d   = row_index_q;
    row_val_num_d = row_val_num_q;
    case (state_q)
      S_IDLE: if (start) row_index_d = '0;
      S_LOAD: begin
        if (in_valid) begin
          row_d         = in_data;
          flag_d        = in_mask;
          pend_d        = in_mask;
          row_val_num_d = in_pop;
        end
      end
      S_FLAG: begin
        if (wr_ready && (flag_q == '0) && !last_row) row_index_d = row_index_q + ACT_INDEX_WIDTH'(1);
      end
      S_DATA: begin
        if (wr_ready) begin
          pend_d = pend_left;
          if ((pend_left == '0) && !last_row) row_index_d = row_index_q + ACT_INDEX_WIDTH'(1);
        end
      end
      S_DONE: row_index_d = '0;
      default: ;
    endcase
  end

  // Outputs decoded from state; write payloads are zeroed outside their request state.
  always_comb begin
    in_ready         = (state_q == S_LOAD);
    wr_req_act_flag  = (state_q == S_FLAG);
    wr_data_act_flag = (state_q == S_FLAG) ? flag_q : '0;
    wr_req_act       = (state_q == S_DATA);
    wr_data_act      = (state_q == S_DATA) ? pick_byte : '0;
    act_index        = (state_q == S_DATA) ? pick_idx : '0;
    row_index        = row_index_q;
    row_val_num      = row_val_num_q;
    busy             = (state_q == S_LOAD) || (state_q == S_FLAG) || (state_q == S_DATA);
    frame_done       = (state_q == S_DONE);
  end

endmodule

// File: tb/tb_act_sparse_encoder.sv
// Directed bench for act_sparse_encoder: reset, sparse/zero/dense rows, backpressure, full frame, reset mid-row.
// Checks are sampled 1 time unit after each rising edge; inputs change at the same point.
// A monitor counts accepted data writes, frame_done pulses and flag/data request overlap.
module tb_act_sparse_encoder;
  localparam int DW   = 8;
  localparam int IFW  = 16;
  localparam int ROWS = 16;
  localparam int AIW  = 4;

  logic              clk = 1'b0;
  logic              reset, start, in_valid, in_ready, wr_ready;
  logic [IFW*DW-1:0] in_data;
  logic              wr_req_act_flag, wr_req_act, busy, frame_done;
  logic [IFW-1:0]    wr_data_act_flag;
  logic [DW-1:0]     wr_data_act;
  logic [AIW-1:0]    act_index, row_index;
  logic [AIW:0]      row_val_num;

  int pass_cnt = 0, chk_cnt = 0, fail_cnt = 0;
  int data_wr_cnt = 0, done_cnt = 0, overlap_cnt = 0;

  localparam logic [IFW*DW-1:0] ROW_A = 128'h00_11_00_00_22_00_00_00_00_00_00_00_00_00_00_33;

  always #5 clk = ~clk;

  act_sparse_encoder #(.DATA_WIDTH(DW), .IF_WIDTH(IFW), .ROWS(ROWS), .ACT_INDEX_WIDTH(AIW)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .wr_ready(wr_ready), .wr_req_act_flag(wr_req_act_flag),
    .wr_data_act_flag(wr_data_act_flag), .wr_req_act(wr_req_act), .wr_data_act(wr_data_act),
    .act_index(act_index), .row_index(row_index), .row_val_num(row_val_num),
    .busy(busy), .frame_done(frame_done)
  );

  always @(posedge clk) begin
    if (wr_req_act && wr_ready) data_wr_cnt++;
    if (frame_done) done_cnt++;
    if (wr_req_act && wr_req_act_flag) overlap_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [IFW-1:0] flag_of(input logic [IFW*DW-1:0] r);
    logic [IFW-1:0] f;
    for (int e = 0; e < IFW; e++) f[IFW-1-e] = (r[IFW*DW-1-DW*e -: DW] != 8'h00);
    return f;
  endfunction

  function automatic int pop_of(input logic [IFW*DW-1:0] r);
    int c;
    c = 0;
    for (int e = 0; e < IFW; e++) if (r[IFW*DW-1-DW*e -: DW] != 8'h00) c++;
    return c;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_flag_req"}, wr_req_act_flag, 0);
    chk({tag, "_flag_dat"}, wr_data_act_flag, 0);
    chk({tag, "_act_req"}, wr_req_act, 0);
    chk({tag, "_act_dat"}, wr_data_act, 0);
    chk({tag, "_act_idx"}, act_index, 0);
    chk({tag, "_row_idx"}, row_index, 0);
    chk({tag, "_row_val"}, row_val_num, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, frame_done, 0);
  endtask

  initial begin
    logic [IFW*DW-1:0] row_v;
    int base_wr, base_done, exp_sum, n, p;

    reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; wr_ready = 1'b0;
    tick; tick;
    chk_all_zero("reset");

    reset = 1'b1; wr_ready = 1'b1;
    tick;
    chk("idle_busy", busy, 0);
    base_wr = data_wr_cnt; base_done = done_cnt;

    // Frame start
    start = 1'b1; tick; start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_in_ready", in_ready, 1);
    chk("start_row_idx", row_index, 0);

    // Row 0: sparse row, flag 4801
    in_valid = 1'b1; in_data = ROW_A; tick; in_valid = 1'b0;
    chk("a_flag_req", wr_req_act_flag, 1);
    chk("a_flag_dat", wr_data_act_flag, 16'h4801);
    chk("a_row_val", row_val_num, 3);
    chk("a_in_ready", in_ready, 0);
    chk("a_act_req0", wr_req_act, 0);
    tick;
    chk("a_d0_req", wr_req_act, 1); chk("a_d0_flagreq", wr_req_act_flag, 0);
    chk("a_d0_idx", act_index, 1);  chk("a_d0_dat", wr_data_act, 8'h11);
    tick;
    chk("a_d1_idx", act_index, 4);  chk("a_d1_dat", wr_data_act, 8'h22);
    tick;
    chk("a_d2_idx", act_index, 15); chk("a_d2_dat", wr_data_act, 8'h33);
    tick;
    chk("a_next_ready", in_ready, 1); chk("a_next_req", wr_req_act, 0);
    chk("a_next_row", row_index, 1);  chk("a_rvn_hold", row_val_num, 3);

    // Row 1: all zero
    in_valid = 1'b1; in_data = '0; tick; in_valid = 1'b0;
    chk("z_flag_req", wr_req_act_flag, 1);
    chk("z_flag_dat", wr_data_act_flag, 16'h0000);
    chk("z_row_val", row_val_num, 0);
    chk("z_act_req", wr_req_act, 0);
    tick;
    chk("z_in_ready", in_ready, 1); chk("z_act_req2", wr_req_act, 0);
    chk("z_row_idx", row_index, 2);

    // Row 2: dense 0x01..0x10
    for (int e = 0; e < IFW; e++) row_v[IFW*DW-1-DW*e -: DW] = DW'(e + 1);
    in_valid = 1'b1; in_data = row_v; tick; in_valid = 1'b0;
    chk("f_flag_dat", wr_data_act_flag, 16'hFFFF);
    chk("f_row_val", row_val_num, 16);
    for (int i = 0; i < IFW; i++) begin
      tick;
      chk("f_req", wr_req_act, 1);
      chk("f_idx", act_index, i);
      chk("f_dat", wr_data_act, i + 1);
    end
    tick;
    chk("f_in_ready", in_ready, 1); chk("f_row_idx", row_index, 3);

    // Row 3: sparse row with wr_ready 1,0,0,1 in the data phase
    in_valid = 1'b1; in_data = ROW_A; tick; in_valid = 1'b0;
    chk("bp_flag_dat", wr_data_act_flag, 16'h4801);
    tick;
    chk("bp_d0_idx", act_index, 1); chk("bp_d0_dat", wr_data_act, 8'h11);
    tick;
    chk("bp_d1_idx", act_index, 4); chk("bp_d1_dat", wr_data_act, 8'h22);
    wr_ready = 1'b0;
    tick;
    chk("bp_s1_req", wr_req_act, 1); chk("bp_s1_idx", act_index, 4);
    chk("bp_s1_dat", wr_data_act, 8'h22); chk("bp_s1_flagreq", wr_req_act_flag, 0);
    tick;
    chk("bp_s2_idx", act_index, 4); chk("bp_s2_dat", wr_data_act, 8'h22);
    wr_ready = 1'b1;
    tick;
    chk("bp_d2_idx", act_index, 15); chk("bp_d2_dat", wr_data_act, 8'h33);
    tick;
    chk("bp_in_ready", in_ready, 1); chk("bp_row_idx", row_index, 4);
    chk("bp_wr_count", data_wr_cnt - base_wr, 22);

    // Rows 4..15: random sparsity, stray start during row 8
    exp_sum = 22;
    for (int r = 4; r < ROWS; r++) begin
      for (int e = 0; e < IFW; e++)
        row_v[IFW*DW-1-DW*e -: DW] = ($urandom_range(0, 1) == 0) ? 8'h00 : DW'($urandom_range(1, 255));
      chk("rnd_in_ready", in_ready, 1);
      chk("rnd_row_idx", row_index, r);
      in_valid = 1'b1; in_data = row_v; tick; in_valid = 1'b0;
      p = pop_of(row_v);
      exp_sum += p;
      chk("rnd_flag_dat", wr_data_act_flag, flag_of(row_v));
      chk("rnd_row_val", row_val_num, p);
      n = 0;
      while (!(in_ready || frame_done) && n < 40) begin
        if (r == 8 && n == 0) start = 1'b1;
        tick;
        start = 1'b0;
        n++;
      end
      chk("rnd_row_cycles", n, p + 1);
    end
    chk("end_done", frame_done, 1);
    chk("end_busy", busy, 0);
    tick;
    chk("post_done", frame_done, 0);
    chk("post_busy", busy, 0);
    chk("post_in_ready", in_ready, 0);
    chk("post_row_idx", row_index, 0);
    chk("frame_wr_total", data_wr_cnt - base_wr, exp_sum);
    chk("frame_done_pulses", done_cnt - base_done, 1);
    chk("no_overlap", overlap_cnt, 0);

    // Reset during the 3rd data write, then a clean restart
    start = 1'b1; tick; start = 1'b0;
    in_valid = 1'b1; in_data = ROW_A; tick; in_valid = 1'b0;
    tick; tick; tick;
    chk("rst_pre_idx", act_index, 15);
    reset = 1'b0;
    tick;
    chk_all_zero("rst_mid");
    reset = 1'b1;
    tick;
    chk("rst_idle_busy", busy, 0);
    chk("rst_idle_ready", in_ready, 0);
    start = 1'b1; tick; start = 1'b0;
    chk("rst_restart_row", row_index, 0);
    chk("rst_restart_ready", in_ready, 1);
    in_valid = 1'b1; in_data = ROW_A; tick; in_valid = 1'b0;
    chk("rst_flag_dat", wr_data_act_flag, 16'h4801);
    chk("rst_row_val", row_val_num, 3);
    tick;
    chk("rst_d0_idx", act_index, 1);
    chk("rst_d0_dat", wr_data_act, 8'h11);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/act_sparse_encoder.md
Name: act_sparse_encoder

Overview:
Converts dense activation rows into the sparse write stream consumed by the activation memory controller: one 16-bit nonzero-flag word per row, followed by that row's nonzero bytes in ascending element order. It sits between the feature-map loader and the controller's activation write ports. It frames a fixed number of rows per feature map and pulses done at the end of each frame.

Parameters:
DATA_WIDTH, 8, bits per activation
IF_WIDTH, 16, elements per row and flag width
ROWS, 16, rows per frame
ACT_INDEX_WIDTH, 4, width of element and row indices (log2 IF_WIDTH)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-low reset
start  in  1  one-cycle pulse that begins a frame; ignored unless IDLE
in_valid  in  1  dense row present on in_data
in_ready  out  1  encoder accepts a row this cycle
in_data  in  IF_WIDTH*DATA_WIDTH  dense row; element 0 in MSBs, element 15 in LSBs
wr_ready  in  1  downstream accepts the current write
wr_req_act_flag  out  1  flag word valid
wr_data_act_flag  out  IF_WIDTH  flag word; bit[15] = element 0 nonzero, bit[0] = element 15 nonzero
wr_req_act  out  1  data byte valid
wr_data_act  out  DATA_WIDTH  nonzero activation byte
act_index  out  ACT_INDEX_WIDTH  element position of wr_data_act
row_index  out  ACT_INDEX_WIDTH  current row within frame
row_val_num  out  ACT_INDEX_WIDTH+1  nonzero count of current row (0..16)
busy  out  1  high from accepted start until frame_done
frame_done  out  1  one-cycle pulse after the last row's final write

Behaviour:
- Reset (reset==0 at a clk edge): state IDLE. All outputs are 0 on the next cycle, and any buffered row is discarded. Reset overrides every other input, including mid-frame.
- States: IDLE, LOAD, FLAG, DATA, DONE.
- IDLE: start=1 -> LOAD, busy=1, row_index=0. start in any other state has no effect.
- LOAD: in_ready=1. If in_valid=1, capture in_data into the row buffer and compute mask[i] = (element i != 0). Also latch row_val_num = popcount(mask), then go to FLAG. in_ready is 0 in every other state.
- FLAG: wr_req_act_flag=1, with wr_data_act_flag = mask.
  - The write completes on the cycle where wr_req_act_flag and wr_ready are both 1.
  - On completion: if mask==0, go to the row-end step; otherwise go to DATA.
- DATA: wr_req_act=1, act_index = lowest-numbered element still set in the pending mask, and wr_data_act = that element's byte.
  - On completion (wr_ready=1), clear that element from the pending mask.
  - If the pending mask becomes empty, go to the row-end step; otherwise present the next element on the following cycle.
  - Exactly row_val_num data writes are issued per row, one per cycle when wr_ready is held high.
- Row-end step: if row_index == ROWS-1, go to DONE. Otherwise increment row_index and go to LOAD.
- DONE: frame_done=1 for exactly one cycle, busy=0, then IDLE. row_index returns to 0.
- Backpressure: while a request is high and wr_ready=0, all wr_* outputs and act_index hold stable, and the state does not advance.
- Flag and data requests are never high in the same cycle.
- Latency with wr_ready tied high:
  - row accepted at cycle t
  - flag write at t+1
  - first data write at t+2
  - last data write at t+1+row_val_num
  - next in_ready at t+2+row_val_num
- Zero row: flag write of 16'h0000 only, with no data writes; in_ready returns at t+2.
- Full row (all nonzero): 16 data writes, act_index 0..15 in order.
- row_val_num and row_index stay valid from FLAG until the next row is accepted.

Test Plan:
- Reset mid-DATA: assert reset=0 during the 3rd data write -> next cycle all outputs are 0 and state is IDLE; a following start encodes from row 0.
- Row 0x00_11_00_00_22_00.._00_33 (element 0=0x00, element 1=0x11, element 4=0x22, element 15=0x33), wr_ready=1 -> flag 0x4801, row_val_num=3, then data 0x11@1, 0x22@4, 0x33@15 on consecutive cycles.
- All-zero row -> one flag write 0x0000, row_val_num=0, no wr_req_act, and in_ready high two cycles after acceptance.
- Dense row with bytes 0x01..0x10 -> flag 0xFFFF, 16 data writes with act_index 0..15 and data 0x01..0x10, no gaps.
- Backpressure: wr_ready toggles 1,0,0,1 during the data phase of the 0x4801 row -> each byte is held stable while stalled, and no byte is lost or duplicated.
- ROWS=16 frame with random sparsity, start pulsed again mid-frame -> the second start is ignored; frame_done pulses once after row 15's last write; busy falls together with frame_done; total data writes equal the sum of all row popcounts.
